// File: rtl/hilo_unit.sv
// HI/LO register file with a 32-step restoring divider for the MIPS EX stage.
// Single-cycle ops update HI/LO at the accepting edge. DIV/DIVU hold Busy high for 33 cycles.
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               op_valid_i,
  input  logic [2:0]         op_i,
  input  logic [2*WIDTH-1:0] product_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               flush_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);

  localparam logic [2:0] OP_MTHI   = 3'b001;
  localparam logic [2:0] OP_MTLO   = 3'b010;
  localparam logic [2:0] OP_LOAD64 = 3'b011;
  localparam logic [2:0] OP_MADD   = 3'b100;
  localparam logic [2:0] OP_MSUB   = 3'b101;
  localparam logic [2:0] OP_DIV    = 3'b110;
  localparam logic [2:0] OP_DIVU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [4:0]       cnt_q, cnt_d;

  logic accept;
  logic is_div;
  logic b_zero;
  logic start_div;

  assign accept    = op_valid_i && (state_q == S_IDLE) && !flush_i;
  assign is_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign b_zero    = (b_i == '0);
  assign start_div = accept && is_div && !b_zero;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_div) state_d = S_RUN;
      S_RUN: begin
        if (flush_i)             state_d = S_IDLE;
        else if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o = (state_q != S_IDLE);
  end

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             signed_op;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, divisor_q};
  assign signed_op = (op_i == OP_DIV);
  assign a_abs     = (signed_op && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
  assign b_abs     = (signed_op && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    if (start_div) begin
      rem_d     = '0;
      quo_d     = a_abs;
      divisor_d = b_abs;
      neg_quo_d = signed_op && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      neg_rem_d = signed_op && a_i[WIDTH-1];
      cnt_d     = 5'd0;
    end else if (state_q == S_RUN) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
    end
  end

  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] hilo_cur;
  logic [2*WIDTH-1:0] hilo_sum;
  logic [2*WIDTH-1:0] hilo_diff;

  assign quo_fix   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
  assign hilo_cur  = {hi_q, lo_q};
  assign hilo_sum  = hilo_cur + product_i;
  assign hilo_diff = hilo_cur - product_i;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    dbz_d = 1'b0;
    if (accept) begin
      case (op_i)
        OP_MTHI:   hi_d = a_i;
        OP_MTLO:   lo_d = a_i;
        OP_LOAD64: {hi_d, lo_d} = product_i;
        OP_MADD:   {hi_d, lo_d} = hilo_sum;
        OP_MSUB:   {hi_d, lo_d} = hilo_diff;
        OP_DIV, OP_DIVU: dbz_d = b_zero;
        default: ;
      endcase
    end
    // A flush in DONE discards the result
    if (state_q == S_DONE && !flush_i) begin
      hi_d = rem_fix;
      lo_d = quo_fix;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= 5'd0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
    end
  end

  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit: single-cycle ops, divides, divide by zero, aborts.
module tb_hilo_unit;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [63:0] product;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        dbz;

  int n_checks = 0;
  int n_fail   = 0;

  hilo_unit #(.WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .op_valid_i   (op_valid),
    .op_i         (op),
    .product_i    (product),
    .a_i          (a),
    .b_i          (b),
    .flush_i      (flush),
    .hi_o         (hi),
    .lo_o         (lo),
    .busy_o       (busy),
    .div_by_zero_o(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an op at the falling edge, let it be taken at the next rising edge,
  // and return 1 time unit after that edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] pv);
    @(negedge clk);
    op       = o;
    a        = av;
    b        = bv;
    product  = pv;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op       = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: hi=%h lo=%h busy=%b dbz=%b, required all zero", hi, lo, busy, dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  task automatic test_move();
    issue(3'b001, 32'h12345678, 32'h0, 64'h0);
    n_checks++;
    if (hi !== 32'h12345678) begin
      n_fail++;
      $display("FAIL mthi: hi=%h, required 12345678", hi);
    end
    issue(3'b010, 32'h9ABCDEF0, 32'h0, 64'h0);
    n_checks++;
    if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678) begin
      n_fail++;
      $display("FAIL mtlo: hi=%h lo=%h, required 12345678 9abcdef0", hi, lo);
    end
    $display("move: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_mac();
    issue(3'b011, 32'h0, 32'h0, 64'h00000001_00000002);
    n_checks++;
    if ({hi, lo} !== 64'h00000001_00000002) begin
      n_fail++;
      $display("FAIL load64: hilo=%h, required 0000000100000002", {hi, lo});
    end
    issue(3'b100, 32'h0, 32'h0, 64'hFFFFFFFF_FFFFFFFF);
    n_checks++;
    if ({hi, lo} !== 64'h00000001_00000001) begin
      n_fail++;
      $display("FAIL madd: hilo=%h, required 0000000100000001", {hi, lo});
    end
    issue(3'b101, 32'h0, 32'h0, 64'h00000001_00000001);
    n_checks++;
    if ({hi, lo} !== 64'h0) begin
      n_fail++;
      $display("FAIL msub: hilo=%h, required 0", {hi, lo});
    end
    issue(3'b000, 32'hDEADBEEF, 32'h0, 64'h12345678_9ABCDEF0);
    n_checks++;
    if ({hi, lo} !== 64'h0) begin
      n_fail++;
      $display("FAIL nop: hilo=%h, required 0", {hi, lo});
    end
    $display("mac: hilo=%h", {hi, lo});
  endtask

  // Issue a divide and count how many sampled cycles Busy stays high; an MTHI
  // is presented for one cycle midway and must be ignored.
  task automatic run_div(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi, input string name);
    int cycles;
    cycles = 0;
    issue(o, av, bv, 64'h0);
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (cycles == 5) begin
        op = 3'b001; a = 32'h5A5A5A5A; op_valid = 1'b1;
      end else if (cycles == 6) begin
        op = 3'b000; op_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (cycles != 33) begin
      n_fail++;
      $display("FAIL %s busy: high %0d cycles, required 33", name, cycles);
    end
    n_checks++;
    if (lo !== exp_lo || hi !== exp_hi) begin
      n_fail++;
      $display("FAIL %s result: lo=%h hi=%h, required lo=%h hi=%h", name, lo, hi, exp_lo, exp_hi);
    end
    $display("%s: a=%h b=%h lo=%h hi=%h busy_cycles=%0d", name, av, bv, lo, hi, cycles);
  endtask

  task automatic test_div();
    run_div(3'b110, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, "div_m7_2");
    run_div(3'b111, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'h0000000F, "divu_max_16");
    run_div(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, "div_min_m1");
  endtask

  task automatic test_back_to_back();
    // Busy fell at the previous edge; this op is taken on the very next one.
    op = 3'b111; a = 32'd100; b = 32'd7; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op = 3'b000;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: busy=%b, required 1", busy);
    end
    for (int i = 0; i < 40 && busy === 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      n_fail++;
      $display("FAIL back_to_back result: lo=%h hi=%h, required lo=e hi=2", lo, hi);
    end
    $display("back_to_back: lo=%h hi=%h", lo, hi);
  endtask

  task automatic test_div_zero();
    int pulses;
    pulses = 0;
    issue(3'b001, 32'h0000AAAA, 32'h0, 64'h0);
    issue(3'b010, 32'h00005555, 32'h0, 64'h0);
    issue(3'b110, 32'h00001234, 32'h0, 64'h0);
    n_checks++;
    if (dbz !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL div0 pulse: dbz=%b busy=%b, required 1 0", dbz, busy);
    end
    for (int i = 0; i < 4; i++) begin
      if (dbz === 1'b1) pulses++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL div0 width: %0d cycles high, required 1", pulses);
    end
    n_checks++;
    if (hi !== 32'h0000AAAA || lo !== 32'h00005555 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL div0 hold: hi=%h lo=%h busy=%b, required aaaa 5555 0", hi, lo, busy);
    end
    $display("div0: hi=%h lo=%h pulses=%0d", hi, lo, pulses);
  endtask

  task automatic test_flush();
    issue(3'b110, 32'd100, 32'd7, 64'h0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush busy: busy=%b, required 0", busy);
    end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (hi !== 32'h0000AAAA || lo !== 32'h00005555) begin
      n_fail++;
      $display("FAIL flush hold: hi=%h lo=%h, required aaaa 5555", hi, lo);
    end
    // Flush in IDLE blocks the op presented alongside it.
    @(negedge clk);
    op = 3'b010; a = 32'h11111111; op_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0; flush = 1'b0; op = 3'b000;
    n_checks++;
    if (lo !== 32'h00005555) begin
      n_fail++;
      $display("FAIL flush idle: lo=%h, required 5555", lo);
    end
    $display("flush: hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  task automatic test_reset_abort();
    issue(3'b110, 32'd100, 32'd7, 64'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: hi=%h lo=%h busy=%b, required 0 0 0", hi, lo, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_abort after: hi=%h lo=%h busy=%b, required 0 0 0", hi, lo, busy);
    end
    $display("reset_abort: hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  initial begin
    op_valid = 1'b0;
    op       = 3'b000;
    product  = 64'h0;
    a        = 32'h0;
    b        = 32'h0;
    flush    = 1'b0;
    test_reset();
    test_move();
    test_mac();
    test_div();
    test_back_to_back();
    test_div_zero();
    test_flush();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

HI/LO register file and iterative divider for the pipelined MIPS core. It sits directly downstream of the EX-stage ALU. It consumes the ALU's 64-bit product for MULT/MULTU/MADD/MSUB and the raw rs/rt operands for MTHI/MTLO/DIV/DIVU. It holds HI/LO for MFHI/MFLO and stalls the pipeline while a divide is in flight.

## Interface
- WIDTH, 32, operand width; only 32 is supported.
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, asynchronous and active-low.
- OpValid  in  1  an HI/LO operation is presented this cycle.
- Op  in  3  operation code:
  - 000 NOP; 001 MTHI; 010 MTLO; 011 LOAD64 (MULT/MULTU).
  - 100 MADD; 101 MSUB; 110 DIV; 111 DIVU.
- Product  in  64  ALU 64-bit result; used by LOAD64/MADD/MSUB.
- A  in  32  rs value (MTHI/MTLO source, dividend).
- B  in  32  rt value (divisor).
- Flush  in  1  squash the current op and abort any running divide.
- Hi  out  32  HI register.
- Lo  out  32  LO register.
- Busy  out  1  divider running; the EX stage must stall while high.
- DivByZero  out  1  one-cycle pulse when a DIV/DIVU has B==0.

## Operation
- Accept rule: an op is accepted on an edge where OpValid=1, Busy=0 and Flush=0. An op presented while Busy=1 is ignored; the pipeline must hold it.
- Single-cycle ops, Hi/Lo updated at the accepting edge:
  - MTHI: Hi<=A.
  - MTLO: Lo<=A.
  - LOAD64: {Hi,Lo}<=Product.
  - MADD: {Hi,Lo}<={Hi,Lo}+Product, modulo 2^64.
  - MSUB: {Hi,Lo}<={Hi,Lo}-Product, modulo 2^64.
  - NOP: no change.
- FSM states: IDLE, RUN, DONE. Busy=1 in RUN and DONE.
- DIV/DIVU accept with B!=0: go IDLE->RUN.
  - Latch |A| and |B| (DIVU: the raw values).
  - Latch a negate-quotient flag (signs differ) and a negate-remainder flag (A negative). Both flags are 0 for DIVU.
  - Counter<=0.
- RUN: one restoring-division step per cycle (shift the remainder/quotient pair left, trial-subtract the divisor, set the quotient bit). Counter increments. The step made at counter==31 moves the FSM to DONE.
- DONE: apply the sign fixes, then Lo<=quotient, Hi<=remainder, go to IDLE.
- Signed semantics: the quotient truncates toward zero; the remainder takes the dividend's sign. -2^31/-1 gives Lo=0x80000000, Hi=0.
- Divide by zero: Hi/Lo are unchanged, the FSM stays IDLE, Busy stays 0, and DivByZero pulses high for the cycle after the accepting edge.
- Flush:
  - In RUN/DONE it returns the FSM to IDLE at the next edge. Hi/Lo are not written and Busy drops.
  - In IDLE it blocks acceptance of the current op.
  - Flush is synchronous.
- MFHI/MFLO read Hi/Lo combinationally. There is no internal bypass; hazard detection stalls readers one cycle after a write.

## Timing
- Reset (async assert) values:
  - Hi=0, Lo=0, Busy=0, DivByZero=0.
  - FSM=IDLE, counter=0, all divider datapath registers 0.
- Reset mid-divide aborts immediately; the outputs take their reset values.
- Single-cycle ops: result is visible on Hi/Lo in the cycle after the accepting edge (latency 1).
- Divide, with the accept edge as E0:
  - Busy is high from after E0 through E33.
  - Hi/Lo are written at E33 and Busy falls at the same edge.
  - The result is visible in the cycle after E33; total latency is 33 cycles.
- Back-to-back: a new op can be accepted on the edge after Busy falls.
- 64-bit MADD/MSUB arithmetic wraps silently; there is no overflow flag.

## Test plan
- Reset, then MTHI A=0x12345678, then MTLO A=0x9ABCDEF0: Hi=0x12345678 and Lo=0x9ABCDEF0, each one cycle after its op.
- LOAD64 Product=0x00000001_00000002, then MADD Product=0xFFFFFFFF_FFFFFFFF: {Hi,Lo}=0x00000001_00000001. Then MSUB Product=0x00000001_00000001: {Hi,Lo}=0.
- DIV A=-7 (0xFFFFFFF9), B=2:
  - Busy high for exactly 33 cycles.
  - Then Lo=0xFFFFFFFD (-3) and Hi=0xFFFFFFFF (-1).
  - An MTHI issued during Busy is ignored.
- DIVU A=0xFFFFFFFF, B=0x10: Lo=0x0FFFFFFF, Hi=0xF. Also DIV A=0x80000000, B=0xFFFFFFFF: Lo=0x80000000, Hi=0.
- DIV with B=0 and Hi/Lo preloaded to 0xAAAA/0x5555: DivByZero pulses once, Busy stays 0, Hi/Lo unchanged.
- Abort cases:
  - Start DIV 100/7 and assert Flush at E10: Busy drops after E10, Hi/Lo keep their pre-divide values.
  - Repeat with Rst pulsed low mid-divide: Hi=Lo=0, Busy=0 immediately.
